ports_pin_capture: RTL and testbench

Input-direction companion to the port output/enable logic. It takes one 8-bit pad input bus, brings it into the core clock domain and exposes the pin levels for SFR reads. It also detects selectable edges on pins configured as inputs and latches per-pin interrupt flags. The flags are cleared by SFR write-1-to-clear strobes. One instance is used per port (P0..P3).

---
 rtl/ports_defs_pkg.sv | 20 ++
 rtl/ports_bit_filter.sv | 32 +++
 rtl/ports_pin_capture.sv | 133 +++++++++++++
 tb/tb_ports_pin_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ports_defs_pkg.sv
// Shared definitions for the port pin-capture slice: FSM encodings and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ports_defs_pkg;

    typedef enum logic {
        PCAP_INIT = 1'b0,
        PCAP_RUN  = 1'b1
    } pcap_state_e;

    localparam int PORTS_WIDTH_DEF       = 8;
    localparam int PORTS_SYNC_STAGES_DEF = 2;
    localparam int PORTS_FILT_LEN_DEF    = 4;

    // Start-up counter must reach 4 sync stages + 15 filter samples.
    localparam int PCAP_INIT_CNT_W = 5;
    // Per-pin glitch counter, holds up to FILT_LEN-1 = 14.
    localparam int PCAP_FILT_CNT_W = 4;

endpackage

// File: rtl/ports_bit_filter.sv
// Single-pin glitch filter: output follows input only after FILT_LEN stable differing samples.
// Latency: FILT_LEN cycles from a stable change of sync_bit to filt_bit.
// Backpressure: none; pulses shorter than FILT_LEN cycles are dropped.
module ports_bit_filter
    import ports_defs_pkg::*;
#(
    parameter int FILT_LEN = PORTS_FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_bit,
    output logic filt_bit
);

    logic [PCAP_FILT_CNT_W-1:0] cnt_q;

    // Count consecutive disagreeing samples; accept the new level on the FILT_LEN-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            filt_bit <= 1'b0;
        end else if (sync_bit == filt_bit) begin
            cnt_q <= '0;
        end else if (cnt_q == PCAP_FILT_CNT_W'(FILT_LEN - 1)) begin
            filt_bit <= sync_bit;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + PCAP_FILT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/ports_pin_capture.sv
// Port input capture: synchronize pads, expose levels, latch per-pin edge flags (optional glitch filter via PORTS_GLITCH_FILTER_EN).
// Latency: pad to PXIN_o SYNC_STAGES cycles (+FILT_LEN with filter); flag one cycle later.
// Backpressure: none; flags held until write-1-to-clear, a simultaneous new edge wins over the clear.
module ports_pin_capture
    import ports_defs_pkg::*;
#(
    parameter int WIDTH       = PORTS_WIDTH_DEF,
    parameter int SYNC_STAGES = PORTS_SYNC_STAGES_DEF,
    parameter int FILT_LEN    = PORTS_FILT_LEN_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] y_portX_i,
    input  logic [WIDTH-1:0] ports_sfr_PXEN_i,
    input  logic [WIDTH-1:0] ports_sfr_PXIE_i,
    input  logic [WIDTH-1:0] ports_sfr_PXEDGE_i,
    input  logic [WIDTH-1:0] ports_sfr_PXIF_clr_i,
    output logic [WIDTH-1:0] ports_sfr_PXIN_o,
    output logic [WIDTH-1:0] ports_sfr_PXIF_o,
    output logic             int_req_o
);

`ifdef PORTS_GLITCH_FILTER_EN
    localparam int FILT_CYCLES = FILT_LEN;
`else
    localparam int FILT_CYCLES = 0 * FILT_LEN;
`endif
    // Terminal count sits one past the settle time so prev samples a settled filt.
    localparam int INIT_TERM = SYNC_STAGES + FILT_CYCLES;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  pxif_q;
    logic [WIDTH-1:0]                  hit;

    pcap_state_e                state_q, state_d;
    logic [PCAP_INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic                       prev_load;
    logic                       edge_en;

    // Plain flop chain per pad bit; index 0 is the first stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], y_portX_i};
        end
    end

`ifdef PORTS_GLITCH_FILTER_EN
    for (genvar b = 0; b < WIDTH; b++) begin : g_filt
        ports_bit_filter #(
            .FILT_LEN(FILT_LEN)
        ) u_filt (
            .clk      (clk_i),
            .rst      (rst_i),
            .sync_bit (sync_q[SYNC_STAGES-1][b]),
            .filt_bit (filt[b])
        );
    end
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    // Pin levels are readable regardless of driver enable (driven value read-back).
    assign ports_sfr_PXIN_o = filt;

    // State and start-up counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PCAP_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Hold off edge detection until the pipeline holds real pad samples.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_load  = 1'b0;
        edge_en    = 1'b0;
        case (state_q)
            PCAP_INIT: begin
                if (init_cnt_q == PCAP_INIT_CNT_W'(INIT_TERM)) begin
                    prev_load = 1'b1;
                    state_d   = PCAP_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + PCAP_INIT_CNT_W'(1);
                end
            end
            PCAP_RUN: begin
                prev_load = 1'b1;
                edge_en   = 1'b1;
            end
            default: state_d = PCAP_INIT;
        endcase
    end

    // Previous filtered sample for edge comparison.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else if (prev_load) begin
            prev_q <= filt;
        end
    end

    // Selected edge on input-direction pins only.
    always_comb begin
        hit = '0;
        if (edge_en) begin
            hit = ((ports_sfr_PXEDGE_i & filt & ~prev_q) |
                   (~ports_sfr_PXEDGE_i & ~filt & prev_q)) & ~ports_sfr_PXEN_i;
        end
    end

    // Sticky flags: clear strobe drops a flag, a same-cycle hit re-sets it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pxif_q <= '0;
        end else begin
            pxif_q <= (pxif_q & ~ports_sfr_PXIF_clr_i) | hit;
        end
    end

    assign ports_sfr_PXIF_o = pxif_q;
    assign int_req_o        = |(pxif_q & ports_sfr_PXIE_i);

endmodule

// File: tb/tb_ports_pin_capture.sv
// Self-checking bench for ports_pin_capture: directed scenarios plus random traffic.
// Expected outputs come from a pad-history reference model pushed into a scoreboard queue.
// A monitor on the falling edge pops one expectation per driven cycle and compares.
module tb_ports_pin_capture;

    localparam int W = 8;
    localparam int S = 2;
    localparam int F = 4;
`ifdef PORTS_GLITCH_FILTER_EN
    localparam int FL = F;
`else
    localparam int FL = 0;
`endif
    localparam int INIT_LEN = S + FL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pad = '0;
    logic [W-1:0] en = '0;
    logic [W-1:0] ie = '0;
    logic [W-1:0] edge_sel = '0;
    logic [W-1:0] clr = '0;
    logic [W-1:0] pxin;
    logic [W-1:0] pxif;
    logic         irq;

    always #5 clk = ~clk;

    ports_pin_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .FILT_LEN    (F)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .y_portX_i            (pad),
        .ports_sfr_PXEN_i     (en),
        .ports_sfr_PXIE_i     (ie),
        .ports_sfr_PXEDGE_i   (edge_sel),
        .ports_sfr_PXIF_clr_i (clr),
        .ports_sfr_PXIN_o     (pxin),
        .ports_sfr_PXIF_o     (pxif),
        .int_req_o            (irq)
    );

    typedef struct packed {
        logic [W-1:0] pxin;
        logic [W-1:0] pxif;
        logic         irq;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;

    // Reference model state: streams of pad samples and the level seen by software.
    logic [W-1:0] pad_hist[$];
    logic [W-1:0] sync_hist[$];
    logic [W-1:0] lvl_hist[$];
    int           cyc;
    logic [W-1:0] m_flags;
    logic [W-1:0] m_hit_prev;
    logic [W-1:0] m_clr_prev;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic model_init();
        pad_hist.delete();
        sync_hist.delete();
        lvl_hist.delete();
        exp_q.delete();
        cyc        = 0;
        m_flags    = '0;
        m_hit_prev = '0;
        m_clr_prev = '0;
    endtask

    // One clock cycle of the reference: current inputs are already applied.
    task automatic model_cycle();
        logic [W-1:0] s;
        logic [W-1:0] lvl;
        logic [W-1:0] old;
        logic [W-1:0] hit;
        logic         flip;
        exp_t         e;
        m_flags = (m_flags & ~m_clr_prev) | m_hit_prev;
        pad_hist.push_back(pad);
        s = (cyc >= S) ? pad_hist[cyc-S] : '0;
        sync_hist.push_back(s);
`ifdef PORTS_GLITCH_FILTER_EN
        lvl = (cyc > 0) ? lvl_hist[cyc-1] : '0;
        if (cyc >= F) begin
            for (int b = 0; b < W; b++) begin
                flip = 1'b1;
                for (int j = 1; j <= F; j++)
                    if (sync_hist[cyc-j][b] == lvl[b]) flip = 1'b0;
                if (flip) lvl[b] = ~lvl[b];
            end
        end
`else
        lvl = s;
`endif
        hit = '0;
        if (cyc >= INIT_LEN + 1) begin
            old = lvl_hist[cyc-1];
            for (int b = 0; b < W; b++)
                if (!en[b] && lvl[b] != old[b] && lvl[b] == edge_sel[b]) hit[b] = 1'b1;
        end
        lvl_hist.push_back(lvl);
        e.pxin = lvl;
        e.pxif = m_flags;
        e.irq  = |(m_flags & ie);
        exp_q.push_back(e);
        m_hit_prev = hit;
        m_clr_prev = clr;
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] i,
                         input logic [W-1:0] g, input logic [W-1:0] c);
        @(posedge clk);
        #1;
        pad = p; en = e; ie = i; edge_sel = g; clr = c;
        model_cycle();
    endtask

    task automatic hold(input int n, input logic [W-1:0] p, input logic [W-1:0] e,
                        input logic [W-1:0] i, input logic [W-1:0] g);
        for (int k = 0; k < n; k++) drive(p, e, i, g, '0);
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once, then release with pad p.
    task automatic apply_reset(input logic [W-1:0] p);
        @(posedge clk);
        #1;
        rst = 1'b1; pad = p; clr = '0;
        #1;
        chk("reset_pxin", pxin, '0);
        chk("reset_pxif", pxif, '0);
        chk("reset_irq", {7'b0, irq}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        model_cycle();
    endtask

    // Scoreboard monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pxin", pxin, e.pxin);
            chk("pxif", pxif, e.pxif);
            chk("irq", {7'b0, irq}, {7'b0, e.irq});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p, e, i, g, c;
        // Pads high through reset: no flags may appear during or after start-up.
        apply_reset(8'hFF);
        hold(12, 8'hFF, 8'h00, 8'h00, 8'h00);

        // Rising edge on bit0 with interrupt enabled, then falling edge is ignored.
        hold(2, 8'hFF, 8'h00, 8'h01, 8'h01);
        hold(8, 8'h00, 8'h00, 8'h01, 8'hFF);
        drive(8'h00, 8'h00, 8'h01, 8'h01, 8'hFF);
        hold(6, 8'h01, 8'h00, 8'h01, 8'h01);
        hold(6, 8'h00, 8'h00, 8'h01, 8'h01);

        // Falling edge on bit3 with interrupts masked, then unmask.
        drive(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        hold(8, 8'h08, 8'h00, 8'h00, 8'h00);
        hold(8, 8'h00, 8'h00, 8'h00, 8'h00);
        hold(3, 8'h00, 8'h00, 8'h08, 8'h00);

        // Bit2 rising: clear collides with a new hit, then a lone clear.
        drive(8'h00, 8'h00, 8'h04, 8'h04, 8'hFF);
        hold(8, 8'h04, 8'h00, 8'h04, 8'h04);
        hold(8, 8'h00, 8'h00, 8'h04, 8'h04);
        drive(8'h04, 8'h00, 8'h04, 8'h04, 8'h00);
        drive(8'h04, 8'h00, 8'h04, 8'h04, 8'h00);
        for (int k = 0; k < S + FL - 1; k++) drive(8'h04, 8'h00, 8'h04, 8'h04, 8'h00);
        drive(8'h04, 8'h00, 8'h04, 8'h04, 8'h04);
        drive(8'h04, 8'h00, 8'h04, 8'h04, 8'h04);
        hold(3, 8'h04, 8'h00, 8'h04, 8'h04);

        // All pins driven: levels follow the pads, no flags.
        drive(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int k = 0; k < 24; k++) begin
            p = (k % 6 < 3) ? 8'hA5 : 8'h5A;
            drive(p, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        end

        // Short and long pulses on bit5, rising edges selected.
        hold(8, 8'h00, 8'h00, 8'h20, 8'h20);
        hold(3, 8'h20, 8'h00, 8'h20, 8'h20);
        hold(10, 8'h00, 8'h00, 8'h20, 8'h20);
        hold(5, 8'h20, 8'h00, 8'h20, 8'h20);
        hold(10, 8'h00, 8'h00, 8'h20, 8'h20);

        // Random traffic: sparse pad toggles, occasional config changes, random clears.
        p = pad; e = en; i = ie; g = edge_sel;
        for (int k = 0; k < 500; k++) begin
            p = p ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(0, 15) == 0) e = W'($urandom) & W'($urandom);
            if ($urandom_range(0, 7) == 0) i = W'($urandom);
            if ($urandom_range(0, 15) == 0) g = W'($urandom);
            c = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            drive(p, e, i, g, c);
        end

        // Reset in the middle of activity, then more random traffic.
        apply_reset(p);
        for (int k = 0; k < 300; k++) begin
            p = p ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(0, 15) == 0) e = W'($urandom) & W'($urandom);
            if ($urandom_range(0, 7) == 0) i = W'($urandom);
            if ($urandom_range(0, 15) == 0) g = W'($urandom);
            c = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            drive(p, e, i, g, c);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
